// File: rtl/cpu_pkg.sv
// Shared opcode, state and control-code definitions for the multicycle RISC control unit.
package cpu_pkg;

    localparam logic [5:0] OP_AND   = 6'h00;
    localparam logic [5:0] OP_ADD   = 6'h01;
    localparam logic [5:0] OP_SUB   = 6'h02;
    localparam logic [5:0] OP_ANDI  = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h05;
    localparam logic [5:0] OP_LWPOI = 6'h06;
    localparam logic [5:0] OP_SW    = 6'h07;
    localparam logic [5:0] OP_BGT   = 6'h08;
    localparam logic [5:0] OP_BLT   = 6'h09;
    localparam logic [5:0] OP_BEQ   = 6'h0A;
    localparam logic [5:0] OP_BNE   = 6'h0B;
    localparam logic [5:0] OP_JMP   = 6'h0C;
    localparam logic [5:0] OP_CALL  = 6'h0D;
    localparam logic [5:0] OP_RET   = 6'h0E;
    localparam logic [5:0] OP_PUSH  = 6'h0F;
    localparam logic [5:0] OP_POP   = 6'h10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_WB2    = 3'd5
    } state_t;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_STACK  = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_INC = 2'd2;

    localparam logic [1:0] ALU_AND = 2'd0;
    localparam logic [1:0] ALU_ADD = 2'd1;
    localparam logic [1:0] ALU_SUB = 2'd2;

    function automatic logic branch_taken(input logic [5:0] op, input logic gt,
                                          input logic lt, input logic eq);
        case (op)
            OP_BGT:  return gt;
            OP_BLT:  return lt;
            OP_BEQ:  return eq;
            OP_BNE:  return !eq;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter shared by instruction fetch and data access; flags a timeout
// on the WAIT_MAX-th consecutive cycle without ready.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic ready,
    output logic timeout
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] cnt;

    assign timeout = waiting && !ready && (cnt == CNT_TC);

    // Any cycle that is not an unanswered wait returns the count to zero,
    // so every entry into FETCH or MEM starts from a clean count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (waiting && !ready && !timeout) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back and
// drives datapath enables from op_code, comparator flags and memory handshakes.
//   state    | meaning
//   S_FETCH  | request instruction, load IR and PC+1 on imem_ready
//   S_DECODE | register read; JMP/CALL/RET resolved here, illegal opcodes dropped
//   S_EXEC   | ALU op, address calc, branch resolve, PUSH/POP request
//   S_MEM    | hold data request until dmem_ready or timeout
//   S_WB     | register write of ALU or memory data
//   S_WB2    | LW.POI post-increment write to rs1
module mc_control_fsm
    import cpu_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op_code,
    input  logic       cmp_gt,
    input  logic       cmp_lt,
    input  logic       cmp_eq,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_load,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       wb_dst,
    output logic [1:0] alu_op,
    output logic       alu_src,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       sp_inc,
    output logic       sp_dec,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state_o
);

    state_t state, state_nx;
    logic   active;
    logic   waiting, ready_sel, timeout, illegal_set;

    // active holds every output low from reset assertion until the first clock after release
    assign waiting     = active && (state == S_FETCH || state == S_MEM);
    assign ready_sel   = (state == S_FETCH) ? imem_ready : dmem_ready;
    assign illegal_set = active && (state == S_DECODE) && (op_code > OP_POP);
    assign state_o     = state;

    mem_wait_timer #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .waiting (waiting),
        .ready   (ready_sel),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            active  <= 1'b0;
            illegal <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            state  <= state_nx;
            active <= 1'b1;
            if (illegal_set) illegal <= 1'b1;
            if (timeout)     bus_err <= 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        if (active) begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) state_nx = S_DECODE;
                end
                S_DECODE: begin
                    if (op_code == OP_JMP || op_code > OP_POP)        state_nx = S_FETCH;
                    else if (op_code == OP_CALL || op_code == OP_RET) state_nx = S_MEM;
                    else                                              state_nx = S_EXEC;
                end
                S_EXEC: begin
                    case (op_code)
                        OP_AND, OP_ADD, OP_SUB, OP_ANDI, OP_ADDI:   state_nx = S_WB;
                        OP_LW, OP_LWPOI, OP_SW, OP_PUSH, OP_POP:    state_nx = S_MEM;
                        default:                                    state_nx = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        if (op_code == OP_LW || op_code == OP_LWPOI || op_code == OP_POP)
                            state_nx = S_WB;
                        else
                            state_nx = S_FETCH;
                    end else if (timeout) begin
                        state_nx = S_FETCH;
                    end
                end
                S_WB:    state_nx = (op_code == OP_LWPOI) ? S_WB2 : S_FETCH;
                default: state_nx = S_FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_INC;
        reg_write = 1'b0;
        wb_sel    = WB_ALU;
        wb_dst    = 1'b0;
        alu_op    = ALU_AND;
        alu_src   = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        sp_inc    = 1'b0;
        sp_dec    = 1'b0;
        if (active) begin
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) begin
                        ir_load  = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_DECODE: begin
                    case (op_code)
                        OP_JMP: begin
                            pc_write = 1'b1;
                            pc_src   = PC_JUMP;
                        end
                        OP_CALL: begin
                            dmem_req = 1'b1;
                            dmem_we  = 1'b1;
                        end
                        OP_RET:  dmem_req = 1'b1;
                        default: ;
                    endcase
                end
                S_EXEC: begin
                    case (op_code)
                        OP_AND:  alu_op = ALU_AND;
                        OP_ADD:  alu_op = ALU_ADD;
                        OP_SUB:  alu_op = ALU_SUB;
                        OP_ANDI: begin
                            alu_op  = ALU_AND;
                            alu_src = 1'b1;
                        end
                        OP_ADDI, OP_LW, OP_LWPOI, OP_SW: begin
                            alu_op  = ALU_ADD;
                            alu_src = 1'b1;
                        end
                        OP_BGT, OP_BLT, OP_BEQ, OP_BNE: begin
                            if (branch_taken(op_code, cmp_gt, cmp_lt, cmp_eq)) begin
                                pc_write = 1'b1;
                                pc_src   = PC_BRANCH;
                            end
                        end
                        OP_PUSH: begin
                            dmem_req = 1'b1;
                            dmem_we  = 1'b1;
                        end
                        OP_POP:  dmem_req = 1'b1;
                        default: ;
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (op_code == OP_SW || op_code == OP_PUSH || op_code == OP_CALL);
                    // Stack pointer and PC only move once the access has completed
                    if (dmem_ready) begin
                        sp_dec = (op_code == OP_PUSH || op_code == OP_CALL);
                        if (op_code == OP_CALL) begin
                            pc_write = 1'b1;
                            pc_src   = PC_JUMP;
                        end
                        if (op_code == OP_RET) begin
                            sp_inc   = 1'b1;
                            pc_write = 1'b1;
                            pc_src   = PC_STACK;
                        end
                    end
                end
                S_WB: begin
                    reg_write = 1'b1;
                    if (op_code == OP_LW || op_code == OP_LWPOI || op_code == OP_POP)
                        wb_sel = WB_MEM;
                    sp_inc = (op_code == OP_POP);
                end
                S_WB2: begin
                    reg_write = 1'b1;
                    wb_dst    = 1'b1;
                    wb_sel    = WB_INC;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized bench: a per-instruction trace generator predicts every cycle's
// handshake inputs and the full control-output vector, compared cycle by cycle.
module tb_mc_control_fsm;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op_code = '0;
    logic       cmp_gt = 1'b0, cmp_lt = 1'b0, cmp_eq = 1'b0;
    logic       imem_ready = 1'b0, dmem_ready = 1'b0;
    logic       imem_req, ir_load, pc_write, reg_write, wb_dst, alu_src;
    logic       dmem_req, dmem_we, sp_inc, sp_dec, illegal, bus_err;
    logic [1:0] pc_src, wb_sel, alu_op;
    logic [2:0] state_o;

    mc_control_fsm #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code),
        .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_load(ir_load), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .wb_sel(wb_sel), .wb_dst(wb_dst),
        .alu_op(alu_op), .alu_src(alu_src), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .sp_inc(sp_inc), .sp_dec(sp_dec), .illegal(illegal), .bus_err(bus_err),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Output vector layout: state[18:16] ireq irl pcw pcs[12:11] rw wbs[9:8] wbd aop[6:5] asrc dreq dwe spi spd
    logic [18:0] obs;
    assign obs = {state_o, imem_req, ir_load, pc_write, pc_src, reg_write, wb_sel, wb_dst,
                  alu_op, alu_src, dmem_req, dmem_we, sp_inc, sp_dec};

    localparam logic [18:0] M_IREQ = 19'd1 << 15;
    localparam logic [18:0] M_IRL  = 19'd1 << 14;
    localparam logic [18:0] M_PCW  = 19'd1 << 13;
    localparam logic [18:0] M_RW   = 19'd1 << 10;
    localparam logic [18:0] M_WBD  = 19'd1 << 7;
    localparam logic [18:0] M_ASRC = 19'd1 << 4;
    localparam logic [18:0] M_DREQ = 19'd1 << 3;
    localparam logic [18:0] M_DWE  = 19'd1 << 2;
    localparam logic [18:0] M_SPI  = 19'd1 << 1;
    localparam logic [18:0] M_SPD  = 19'd1;

    function automatic logic [18:0] st(input int s);  return 19'(s) << 16; endfunction
    function automatic logic [18:0] pcs(input int s); return 19'(s) << 11; endfunction
    function automatic logic [18:0] wbs(input int s); return 19'(s) << 8;  endfunction
    function automatic logic [18:0] aop(input int s); return 19'(s) << 5;  endfunction

    typedef struct packed {
        logic        ir;
        logic        dr;
        logic [18:0] v;
    } cyc_t;

    cyc_t tr[$];
    bit   ill_exp = 1'b0;
    bit   bus_exp = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (op %h, t=%0t)", tag, got, exp, op_code, $time);
        end
    endtask

    task automatic add(input logic ir, input logic dr, input logic [18:0] v);
        tr.push_back({ir, dr, v});
    endtask

    task automatic wb_phase(input int op);
        bit from_mem = (op == 5 || op == 6 || op == 16);
        add(0, 0, st(4) | M_RW | wbs(from_mem ? 1 : 0) | ((op == 16) ? M_SPI : 19'd0));
        if (op == 6) add(0, 0, st(5) | M_RW | M_WBD | wbs(2));
    endtask

    task automatic mem_phase(input int op, input int dw);
        bit          we = (op == 7 || op == 15 || op == 13);
        logic [18:0] base = st(3) | M_DREQ | (we ? M_DWE : 19'd0);
        logic [18:0] done = base;
        for (int i = 0; i < dw && i < WAIT_MAX; i++) add(0, 0, base);
        if (dw >= WAIT_MAX) begin
            bus_exp = 1'b1;
            return;
        end
        if (op == 15 || op == 13) done |= M_SPD;
        if (op == 13) done |= M_PCW | pcs(2);
        if (op == 14) done |= M_SPI | M_PCW | pcs(3);
        add(0, 1, done);
        if (op == 5 || op == 6 || op == 16) wb_phase(op);
    endtask

    // Expected per-cycle trace of one instruction given imem/dmem wait counts
    task automatic build(input int op, input bit gt, input bit lt, input bit eq,
                         input int iw, input int dw);
        bit taken;
        tr.delete();
        for (int i = 0; i < iw; i++) add(0, 0, st(0) | M_IREQ);
        if (iw >= WAIT_MAX) bus_exp = 1'b1;
        add(1, 0, st(0) | M_IREQ | M_IRL | M_PCW | pcs(0));
        if (op == 12) begin add(0, 0, st(1) | M_PCW | pcs(2)); return; end
        if (op > 16)  begin add(0, 0, st(1)); ill_exp = 1'b1; return; end
        if (op == 13) begin add(0, 0, st(1) | M_DREQ | M_DWE); mem_phase(op, dw); return; end
        if (op == 14) begin add(0, 0, st(1) | M_DREQ); mem_phase(op, dw); return; end
        add(0, 0, st(1));
        if (op <= 2) begin add(0, 0, st(2) | aop(op)); wb_phase(op); end
        else if (op <= 4) begin add(0, 0, st(2) | aop(op - 3) | M_ASRC); wb_phase(op); end
        else if (op <= 7) begin add(0, 0, st(2) | aop(1) | M_ASRC); mem_phase(op, dw); end
        else if (op <= 11) begin
            taken = (op == 8) ? gt : (op == 9) ? lt : (op == 10) ? eq : !eq;
            add(0, 0, st(2) | (taken ? (M_PCW | pcs(1)) : 19'd0));
        end
        else if (op == 15) begin add(0, 0, st(2) | M_DREQ | M_DWE); mem_phase(op, dw); end
        else begin add(0, 0, st(2) | M_DREQ); mem_phase(op, dw); end
    endtask

    // Called at posedge+1; leaves at posedge+1 of the cycle after the last record
    task automatic run_trace(input int n);
        for (int i = 0; i < n && i < tr.size(); i++) begin
            imem_ready = tr[i].ir;
            dmem_ready = tr[i].dr;
            @(negedge clk);
            chk($sformatf("cyc%0d", i), 32'(obs), 32'(tr[i].v));
            @(posedge clk);
            #1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic instr(input int op, input bit gt, input bit lt, input bit eq,
                         input int iw, input int dw);
        op_code = 6'(op);
        cmp_gt = gt; cmp_lt = lt; cmp_eq = eq;
        build(op, gt, lt, eq, iw, dw);
        run_trace(tr.size());
        chk("flags", {30'd0, illegal, bus_err}, {30'd0, ill_exp, bus_exp});
    endtask

    initial begin
        int op, iw, dw;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", 32'(obs), 32'd0);
        chk("reset_flags", {30'd0, illegal, bus_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        instr(1, 0, 0, 0, 0, 0);          // ADD, 4 cycles
        instr(6, 0, 0, 0, 0, 3);          // LW.POI, 3 MEM wait cycles
        instr(10, 0, 0, 1, 0, 0);         // BEQ taken
        instr(10, 1, 0, 0, 1, 0);         // BEQ not taken
        instr(13, 0, 0, 0, 0, 2);         // CALL
        instr(14, 0, 0, 0, 0, 1);         // RET
        instr(12, 0, 0, 0, 2, 0);         // JMP
        instr(15, 0, 0, 0, 0, 0);         // PUSH
        instr(16, 0, 0, 0, 0, 1);         // POP
        instr(1, 0, 0, 0, WAIT_MAX, 0);   // fetch timeout then ADD
        instr(7, 0, 0, 0, 0, WAIT_MAX);   // SW data timeout
        instr(63, 0, 0, 0, 0, 0);         // illegal opcode

        // Reset asserted during MEM of SW
        op_code = 6'h07;
        build(7, 0, 0, 0, 0, 6);
        run_trace(5);
        rst_n = 1'b0;
        #1;
        chk("rst_async_out", 32'(obs), 32'd0);
        chk("rst_async_flags", {30'd0, illegal, bus_err}, 32'd0);
        ill_exp = 1'b0;
        bus_exp = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_hold", 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_restart", 32'(obs), 32'(st(0) | M_IREQ));

        for (int k = 0; k < 200; k++) begin
            op = ($urandom_range(0, 11) == 0) ? int'($urandom_range(17, 63)) : int'($urandom_range(0, 16));
            iw = ($urandom_range(0, 24) == 0) ? WAIT_MAX + int'($urandom_range(0, 3)) : int'($urandom_range(0, 3));
            dw = ($urandom_range(0, 24) == 0) ? WAIT_MAX : int'($urandom_range(0, 4));
            instr(op, 1'($urandom), 1'($urandom), 1'($urandom), iw, dw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
